// File: rtl/mem_stage_sram_wide_pkg.sv
// Shared types and helpers for the wide-word SRAM MEM stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Per-beat wait counter; WAIT_CYCLES is limited to 0..15.
    typedef logic [3:0] wait_cnt_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_sram_wide_beat_ctrl.sv
// SRAM beat sequencer: walks BEATS consecutive SRAM words per CPU access,
// drives the data bus for stores and assembles load data low beat first.
module sram_beat_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_is_store,
    input  logic [SRAM_AW-1:0] i_base_addr,
    input  logic [DATA_W-1:0]  i_store_data,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic               o_sram_we_n,
    output logic               o_idle,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_result
);

    localparam int BEATS  = DATA_W / SRAM_DW;
    localparam int BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam wait_cnt_t WAIT_LAST = wait_cnt_t'(WAIT_CYCLES);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    state_t             r_state;
    logic [BEAT_W-1:0]  r_beat;
    wait_cnt_t          r_wait;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic               r_is_store;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rd_buf;
    logic [DATA_W-1:0]  r_result;

    logic [SRAM_DW-1:0] w_wr_slice [BEATS];
    logic [DATA_W-1:0]  w_rd_assembled;
    logic               w_beat_end;
    logic               w_drive;

    // Slice views: the current beat's store slice, and the read buffer with
    // the live bus value merged into the current beat's slot.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slice
            assign w_wr_slice[gi] = r_wdata[gi*SRAM_DW +: SRAM_DW];
            assign w_rd_assembled[gi*SRAM_DW +: SRAM_DW] =
                (r_beat == BEAT_W'(gi)) ? sram_dq : r_rd_buf[gi*SRAM_DW +: SRAM_DW];
        end
    endgenerate

    assign w_beat_end  = (r_wait == WAIT_LAST);
    assign w_drive     = (r_state == ST_ACCESS) && r_is_store;
    assign o_sram_we_n = ~w_drive;
    assign sram_dq     = w_drive ? w_wr_slice[r_beat] : 'z;
    assign o_sram_addr = r_sram_addr;
    assign o_idle      = (r_state == ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_result    = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_wait      <= '0;
            r_sram_addr <= '0;
            r_is_store  <= 1'b0;
            r_wdata     <= '0;
            r_rd_buf    <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_ACCESS;
                        r_beat      <= '0;
                        r_wait      <= '0;
                        r_sram_addr <= i_base_addr;
                        r_is_store  <= i_is_store;
                        r_wdata     <= i_store_data;
                    end
                end
                ST_ACCESS: begin
                    if (w_beat_end) begin
                        r_wait <= '0;
                        if (!r_is_store) begin
                            r_rd_buf <= w_rd_assembled;
                        end
                        if (r_beat == BEAT_LAST) begin
                            r_state <= ST_DONE;
                            // Result only changes once the whole word is in.
                            if (!r_is_store) begin
                                r_result <= w_rd_assembled;
                            end
                        end else begin
                            r_beat      <= r_beat + 1'b1;
                            r_sram_addr <= r_sram_addr + 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_sram_wide.sv
// MEM stage mapping CPU byte addresses onto a narrow external SRAM window.
// Optional single-entry load bypass buffer enabled by SRAM_RD_BYPASS_EN.
module mem_stage_sram_wide
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               wb_en,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [4:0]         dest,
    input  logic [DATA_W-1:0]  store_data,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [31:0]        pc_out,
    output logic [DATA_W-1:0]  alu_result_out,
    output logic               mem_read_out,
    output logic [4:0]         dest_out,
    output logic               wb_en_out,
    output logic [DATA_W-1:0]  mem_result,
    output logic               freeze
);

    localparam int BEATS   = DATA_W / SRAM_DW;
    localparam int BYTE_SH = clog2(DATA_W / 8);

    logic [DATA_W-1:0]  w_offset;
    logic [DATA_W-1:0]  w_word;
    logic [SRAM_AW-1:0] w_base_addr;
    logic               w_req;
    logic               w_start;
    logic               w_idle;
    logic               w_done;
    logic [DATA_W-1:0]  w_result;

    // Truncating the word before scaling gives the same low SRAM_AW bits.
    assign w_offset    = alu_result - DATA_W'(BASE_ADDR);
    assign w_word      = w_offset >> BYTE_SH;
    assign w_base_addr = SRAM_AW'(w_word) * SRAM_AW'(BEATS);
    assign w_req       = mem_read | mem_write;

    assign pc_out         = pc_in;
    assign alu_result_out = alu_result;
    assign mem_read_out   = mem_read;
    assign dest_out       = dest;
    assign wb_en_out      = wb_en & ~freeze;

    sram_beat_ctrl #(
        .DATA_W      (DATA_W),
        .SRAM_DW     (SRAM_DW),
        .SRAM_AW     (SRAM_AW),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_beat_ctrl (
        .clk          (clk),
        .rst_n        (rst),
        .i_start      (w_start),
        .i_is_store   (mem_write),
        .i_base_addr  (w_base_addr),
        .i_store_data (store_data),
        .sram_dq      (sram_dq),
        .o_sram_addr  (sram_addr),
        .o_sram_we_n  (sram_we_n),
        .o_idle       (w_idle),
        .o_done       (w_done),
        .o_result     (w_result)
    );

`ifdef SRAM_RD_BYPASS_EN
    logic              r_bp_valid;
    logic [DATA_W-1:0] r_bp_word;
    logic [DATA_W-1:0] r_bp_data;
    logic [DATA_W-1:0] r_req_word;
    logic [DATA_W-1:0] r_req_data;
    logic              r_req_store;
    logic              w_hit;

    assign w_hit      = mem_read & ~mem_write & w_idle & r_bp_valid & (r_bp_word == w_word);
    assign w_start    = w_idle & w_req & ~w_hit;
    assign mem_result = w_hit ? r_bp_data : w_result;
    assign freeze     = w_req & ~w_done & ~w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bp_valid  <= 1'b0;
            r_bp_word   <= '0;
            r_bp_data   <= '0;
            r_req_word  <= '0;
            r_req_data  <= '0;
            r_req_store <= 1'b0;
        end else begin
            if (w_start) begin
                r_req_word  <= w_word;
                r_req_data  <= store_data;
                r_req_store <= mem_write;
            end
            // Loads refill the entry; stores keep a matching entry coherent.
            if (w_done) begin
                if (!r_req_store) begin
                    r_bp_valid <= 1'b1;
                    r_bp_word  <= r_req_word;
                    r_bp_data  <= w_result;
                end else if (r_bp_valid && (r_bp_word == r_req_word)) begin
                    r_bp_data <= r_req_data;
                end
            end
        end
    end
`else
    assign w_start    = w_idle & w_req;
    assign mem_result = w_result;
    assign freeze     = w_req & ~w_done;
`endif

endmodule
